// File: rtl/rvtu_mul_arb_if.sv
// Packet stream carrying a 36-bit {pid, data} word with empty/deq handshake.
// The master side owns the data (empty, pkt); the slave side pops with deq.
interface rvtu_mul_arb_if;
  logic        empty;
  logic        deq;
  logic [35:0] pkt;

  modport master (output empty, output pkt, input deq);
  modport slave  (input empty, input pkt, output deq);
endinterface

// File: rtl/rvtu_mul_arb.sv
// Two requesters share one multiplier: a src1 load (pid 11) locks its requester until the op,
// results return to per-requester one-entry buffers via an order FIFO. RVTU_MUL_ARB_FAIR_EN: round-robin IDLE pick.
module rvtu_mul_arb #(
  parameter int ORD_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  rvtu_mul_arb_if.slave  rq0,
  rvtu_mul_arb_if.slave  rq1,
  rvtu_mul_arb_if.master rsp0,
  rvtu_mul_arb_if.master rsp1,
  rvtu_mul_arb_if.master mul_ig,
  rvtu_mul_arb_if.slave  mul_eg,
  output logic [1:0]    err
);
  localparam int          AW       = $clog2(ORD_DEPTH);
  localparam logic [AW:0] ORD_FULL = (AW+1)'(ORD_DEPTH);
  localparam logic [3:0]  PID_LD   = 4'd11;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t state;
  logic   owner;
`ifdef RVTU_MUL_ARB_FAIR_EN
  logic   ptr;
`endif

  logic [1:0]  rq_vld;
  logic        idle_sel, sel, sel_vld, sel_ld, sel_op;
  logic        fwd_ok, ig_xfer, drop, push;
  logic [35:0] sel_pkt;

  logic [ORD_DEPTH-1:0] ord_mem;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          ord_cnt;
  logic                 ord_full, tgt, tgt_free, eg_xfer;
  logic [1:0]           rsp_full, rsp_pop;
  logic [35:0]          rsp_dat [2];

  assign rq_vld = {!rq1.empty, !rq0.empty};

  // Head selection: the owner while locked, otherwise the arbitration winner.
  always_comb begin
`ifdef RVTU_MUL_ARB_FAIR_EN
    idle_sel = (rq_vld == 2'b11) ? ptr : rq_vld[1];
`else
    idle_sel = !rq_vld[0];
`endif
    sel     = (state == LOCK) ? owner : idle_sel;
    sel_vld = sel ? rq_vld[1] : rq_vld[0];
    sel_pkt = sel ? rq1.pkt : rq0.pkt;
    sel_ld  = (sel_pkt[35:32] == PID_LD);
    sel_op  = (sel_pkt[35:34] == 2'b11);
  end

  // Ops need an order-FIFO slot; loads always pass; illegal pids are dropped.
  assign ord_full     = (ord_cnt == ORD_FULL);
  assign fwd_ok       = sel_vld && (sel_ld || (sel_op && !ord_full));
  assign ig_xfer      = fwd_ok && mul_ig.deq;
  assign drop         = sel_vld && !sel_ld && !sel_op;
  assign push         = ig_xfer && sel_op;
  assign mul_ig.empty = !fwd_ok;
  assign mul_ig.pkt   = sel_pkt;
  assign rq0.deq      = (ig_xfer || drop) && !sel;
  assign rq1.deq      = (ig_xfer || drop) && sel;

  assign tgt        = ord_mem[rd_ptr];
  assign rsp_pop    = rsp_full & {rsp1.deq, rsp0.deq};
  assign tgt_free   = !rsp_full[tgt] || rsp_pop[tgt];
  assign mul_eg.deq = !mul_eg.empty && (ord_cnt != '0) && tgt_free;
  assign eg_xfer    = mul_eg.deq;

  assign rsp0.empty = !rsp_full[0];
  assign rsp1.empty = !rsp_full[1];
  assign rsp0.pkt   = rsp_dat[0];
  assign rsp1.pkt   = rsp_dat[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      err   <= 2'b00;
`ifdef RVTU_MUL_ARB_FAIR_EN
      ptr   <= 1'b0;
`endif
    end else begin
      if (drop)
        err[0] <= 1'b1;
      if (ig_xfer) begin
        if (sel_ld) begin
          if (state == IDLE) begin
            state <= LOCK;
            owner <= sel;
          end
        end else begin
          if (state == LOCK)
            state <= IDLE;
          else
            err[1] <= 1'b1;
`ifdef RVTU_MUL_ARB_FAIR_EN
          ptr <= ~sel;
`endif
        end
      end
    end
  end

  // Order FIFO of requester ids, one entry per forwarded op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ord_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ord_cnt <= '0;
    end else begin
      if (push) begin
        ord_mem[wr_ptr] <= sel;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (eg_xfer)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !eg_xfer)
        ord_cnt <= ord_cnt + 1'b1;
      else if (!push && eg_xfer)
        ord_cnt <= ord_cnt - 1'b1;
    end
  end

  // A write wins over a same-cycle pop so the buffer stays full with the new result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_full   <= 2'b00;
      rsp_dat[0] <= '0;
      rsp_dat[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (eg_xfer && (int'(tgt) == i)) begin
          rsp_full[i] <= 1'b1;
          rsp_dat[i]  <= mul_eg.pkt;
        end else if (rsp_pop[i]) begin
          rsp_full[i] <= 1'b0;
        end
      end
    end
  end
endmodule
